// File: rtl/sequential_alu.sv
// sequential_alu: multi-cycle ALU with a Start/Busy/Done handshake.
// Logic and add/sub finish in one edge, shifts/rotates step one bit per edge,
// and MUL is an iterative shift-add multiplier.
// Optional feature macro: SEQ_ALU_MUL_EN builds the multiplier for FunSel 13;
// without it FunSel 13 behaves like the reserved codes (PASS A).
module sequential_alu #(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WF,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam logic [3:0] OP_PASS  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NAND  = 4'd7;
  localparam logic [3:0] OP_LSL   = 4'd8;
  localparam logic [3:0] OP_LSR   = 4'd9;
  localparam logic [3:0] OP_ASR   = 4'd10;
  localparam logic [3:0] OP_ROL   = 4'd11;
  localparam logic [3:0] OP_ROR   = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_RSV14 = 4'd14;
  localparam logic [3:0] OP_RSV15 = 4'd15;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state, nextState;

  logic [3:0]       opReg;
  logic [WIDTH-1:0] aReg, bReg;
  logic             wfReg, cinReg, zeroShift;
  logic [SH_W-1:0]  count, startCount;
  logic [SH_W-1:0]  shAmt;
  logic [WIDTH-1:0] shiftReg, shiftNext;
  logic             shiftOut;
  logic             finish;
  logic [WIDTH:0]   sumExt;
  logic [WIDTH-1:0] result;
  logic             flagZ, flagC, flagN, flagO;

  assign shAmt  = B[SH_W-1:0];
  assign Busy   = (state == EXEC);
  // ADC uses the carry captured at Start; FlagsOut cannot change while busy anyway.
  assign sumExt = {1'b0, aReg} + {1'b0, bReg} + {{WIDTH{1'b0}}, (opReg == OP_ADC) & cinReg};

`ifdef SEQ_ALU_MUL_EN
  // {high half, multiplier}; each step conditionally adds A into the high half and shifts right.
  logic [2*WIDTH-1:0] prodReg, prodNext;
  logic [WIDTH:0]     prodHi;

  // One shift-add multiplier step from the current accumulator.
  always_comb begin
    prodHi   = {1'b0, prodReg[2*WIDTH-1:WIDTH]} + (prodReg[0] ? {1'b0, aReg} : '0);
    prodNext = {prodHi, prodReg[WIDTH-1:1]};
  end

  // Accumulator is seeded with B at Start and stepped every busy edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      prodReg <= '0;
    else if (state == IDLE && Start)
      prodReg <= {{WIDTH{1'b0}}, B};
    else if (state == EXEC)
      prodReg <= prodNext;
  end
`endif

  // State register for the IDLE/EXEC controller.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Next-state logic: leave EXEC on the edge where the countdown reaches zero.
  always_comb begin
    nextState = state;
    finish    = 1'b0;
    case (state)
      IDLE: if (Start) nextState = EXEC;
      EXEC: begin
        if (count == '0) begin
          nextState = IDLE;
          finish    = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Remaining busy edges after the first, chosen from the op being accepted.
  always_comb begin
    startCount = '0;
    case (FunSel)
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR:
        if (shAmt != '0) startCount = shAmt - SH_W'(1);
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: startCount = SH_W'(WIDTH - 1);
`endif
      default: startCount = '0;
    endcase
  end

  // One-bit shift/rotate step and the bit that falls out of it.
  always_comb begin
    shiftNext = shiftReg;
    shiftOut  = 1'b0;
    case (opReg)
      OP_LSL: begin shiftNext = {shiftReg[WIDTH-2:0], 1'b0};            shiftOut = shiftReg[WIDTH-1]; end
      OP_LSR: begin shiftNext = {1'b0, shiftReg[WIDTH-1:1]};            shiftOut = shiftReg[0];       end
      OP_ASR: begin shiftNext = {shiftReg[WIDTH-1], shiftReg[WIDTH-1:1]}; shiftOut = shiftReg[0];     end
      OP_ROL: begin shiftNext = {shiftReg[WIDTH-2:0], shiftReg[WIDTH-1]}; shiftOut = shiftReg[WIDTH-1]; end
      OP_ROR: begin shiftNext = {shiftReg[0], shiftReg[WIDTH-1:1]};     shiftOut = shiftReg[0];       end
      default: begin shiftNext = shiftReg; shiftOut = 1'b0; end
    endcase
  end

  // Final result and flag values, consumed only on the finishing edge.
  always_comb begin
    result = aReg;
    flagC  = FlagsOut[2];
    flagO  = FlagsOut[0];
    flagN  = 1'b0;
    case (opReg)
      OP_PASS: result = aReg;
      OP_ADD, OP_ADC: begin
        result = sumExt[WIDTH-1:0];
        flagC  = sumExt[WIDTH];
        flagO  = (aReg[WIDTH-1] == bReg[WIDTH-1]) && (sumExt[WIDTH-1] != aReg[WIDTH-1]);
      end
      OP_SUB: begin
        result = aReg - bReg;
        flagC  = (aReg >= bReg);
        flagO  = (aReg[WIDTH-1] != bReg[WIDTH-1]) && (result[WIDTH-1] == bReg[WIDTH-1]);
      end
      OP_AND:  result = aReg & bReg;
      OP_OR:   result = aReg | bReg;
      OP_XOR:  result = aReg ^ bReg;
      OP_NAND: result = ~(aReg & bReg);
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
        result = zeroShift ? shiftReg : shiftNext;
        flagC  = zeroShift ? FlagsOut[2] : shiftOut;
      end
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: begin
        result = prodNext[WIDTH-1:0];
        flagO  = |prodNext[2*WIDTH-1:WIDTH];
      end
`else
      OP_MUL: result = aReg;
`endif
      OP_RSV14, OP_RSV15: result = aReg;
      default: result = aReg;
    endcase
    flagZ = (result == '0);
    flagN = (opReg == OP_ASR) ? FlagsOut[1] : result[WIDTH-1];
  end

  // Operand capture at Start, countdown while busy, and result/flag write-back at Done.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      wfReg     <= 1'b0;
      cinReg    <= 1'b0;
      zeroShift <= 1'b0;
      count     <= '0;
      shiftReg  <= '0;
      Done      <= 1'b0;
      ALUOut    <= '0;
      FlagsOut  <= '0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE && Start) begin
        opReg     <= FunSel;
        aReg      <= A;
        bReg      <= B;
        wfReg     <= WF;
        cinReg    <= FlagsOut[2];
        zeroShift <= (shAmt == '0);
        count     <= startCount;
        shiftReg  <= A;
      end else if (state == EXEC) begin
        shiftReg <= shiftNext;
        if (finish) begin
          count  <= '0;
          Done   <= 1'b1;
          ALUOut <= result;
          if (wfReg)
            FlagsOut <= {flagZ, flagC, flagN, flagO};
        end else begin
          count <= count - SH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sequential_alu.sv
// Testbench for sequential_alu (WIDTH=16): directed plan cases plus random
// operations checked against an arithmetic reference model.
module tb_sequential_alu;

  localparam int W = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [3:0]    FunSel = '0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          WF = 1'b0;
  logic          Busy, Done;
  logic [W-1:0]  ALUOut;
  logic [3:0]    FlagsOut;

  int            checks = 0;
  int            failures = 0;
  logic [3:0]    modelFlags = '0;
  logic [15:0]   expRes;
  logic [3:0]    expFlags;
  int            expLat;

  sequential_alu #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel),
    .A(A), .B(B), .WF(WF), .Busy(Busy), .Done(Done),
    .ALUOut(ALUOut), .FlagsOut(FlagsOut)
  );

  // Free-running clock, 10 ns period.
  always #5 Clock = ~Clock;

  // Global time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: computes result, flags and latency from the operation rules.
  task automatic modelOp(input logic [3:0] fun, input int unsigned a, input int unsigned b, input logic wf);
    int unsigned res, sum;
    longint unsigned prod;
    int sh, sx;
    logic z, c, n, o;
    {z, c, n, o} = modelFlags;
    sh = int'(b % 16);
    expLat = 1;
    res = a;
    case (fun)
      4'd1, 4'd2: begin
        sum = a + b + ((fun == 4'd2 && c) ? 1 : 0);
        res = sum & 32'hFFFF;
        c = (sum > 32'hFFFF);
        o = (a[15] == b[15]) && (res[15] != a[15]);
      end
      4'd3: begin
        res = (a - b) & 32'hFFFF;
        c = (a >= b);
        o = (a[15] != b[15]) && (res[15] == b[15]);
      end
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd7: res = (~(a & b)) & 32'hFFFF;
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
        if (sh != 0) begin
          expLat = sh;
          case (fun)
            4'd8:  begin res = (a << sh) & 32'hFFFF; c = a[16-sh]; end
            4'd9:  begin res = a >> sh; c = a[sh-1]; end
            4'd10: begin
              sx = a[15] ? int'(a) - 65536 : int'(a);
              res = unsigned'(sx >>> sh) & 32'hFFFF;
              c = a[sh-1];
            end
            4'd11: begin res = ((a << sh) | (a >> (16 - sh))) & 32'hFFFF; c = res[0]; end
            default: begin res = ((a >> sh) | (a << (16 - sh))) & 32'hFFFF; c = res[15]; end
          endcase
        end
      end
`ifdef SEQ_ALU_MUL_EN
      4'd13: begin
        prod = longint'(a) * longint'(b);
        res = int'(prod & 64'hFFFF);
        o = ((prod >> 16) != 0);
        expLat = 16;
      end
`endif
      default: res = a;
    endcase
    z = (res == 0);
    if (fun != 4'd10) n = res[15];
    if (wf) modelFlags = {z, c, n, o};
    expRes = res[15:0];
    expFlags = modelFlags;
  endtask

  // Issues one op, jams junk Start/operands while busy, and checks latency, result and flags.
  task automatic applyStimulus(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b, input logic wf);
    int lat;
    modelOp(fun, a, b, wf);
    FunSel = fun; A = a; B = b; WF = wf; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    checkOutput("busyOnAccept", Busy, 1);
    checkOutput("noDoneOnAccept", Done, 0);
    lat = 0;
    while (!Done && lat < 300) begin
      Start = 1'($urandom_range(0, 1));
      FunSel = 4'($urandom); A = 16'($urandom); B = 16'($urandom); WF = 1'($urandom);
      @(posedge Clock); #1;
      lat++;
    end
    Start = 1'b0;
    checkOutput("latency", lat, expLat);
    checkOutput("result", ALUOut, expRes);
    checkOutput("flags", FlagsOut, expFlags);
    checkOutput("busyAtDone", Busy, 0);
  endtask

  initial begin
    logic sawDone;
    logic [3:0] fun;
    logic [15:0] ra, rb;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("rstBusy", Busy, 0);
    checkOutput("rstDone", Done, 0);
    checkOutput("rstOut", ALUOut, 0);
    checkOutput("rstFlags", FlagsOut, 0);
    @(negedge Clock);
    Reset = 1'b1;
    modelFlags = '0;

    // ADD with signed overflow
    @(negedge Clock);
    applyStimulus(4'd1, 16'h7FFF, 16'h0001, 1'b1);
    checkOutput("addPlanOut", ALUOut, 16'h8000);
    checkOutput("addPlanFlags", FlagsOut, 4'b0011);

    // SUB pair issued back to back
    @(negedge Clock);
    applyStimulus(4'd3, 16'h0003, 16'h0005, 1'b1);
    checkOutput("sub1Out", ALUOut, 16'hFFFE);
    checkOutput("sub1Flags", FlagsOut, 4'b0010);
    applyStimulus(4'd3, 16'h0005, 16'h0005, 1'b1);
    checkOutput("sub2Out", ALUOut, 16'h0000);
    checkOutput("sub2Flags", FlagsOut, 4'b1100);

    // Multi-cycle shifts; ASR leaves N alone
    @(negedge Clock);
    applyStimulus(4'd8, 16'h8001, 16'h0003, 1'b1);
    checkOutput("lslOut", ALUOut, 16'h0008);
    applyStimulus(4'd10, 16'h8000, 16'h000F, 1'b1);
    checkOutput("asrOut", ALUOut, 16'hFFFF);
    checkOutput("asrFlags", FlagsOut, 4'b0000);

`ifdef SEQ_ALU_MUL_EN
    @(negedge Clock);
    applyStimulus(4'd13, 16'h0100, 16'h0100, 1'b1);
    checkOutput("mulOut", ALUOut, 16'h0000);
    checkOutput("mulFlags", FlagsOut, 4'b1001);
    applyStimulus(4'd13, 16'h0100, 16'h0100, 1'b0);
    checkOutput("mulNoWfFlags", FlagsOut, 4'b1001);
`else
    @(negedge Clock);
    applyStimulus(4'd13, 16'h1234, 16'h0000, 1'b1);
    checkOutput("mulRsvOut", ALUOut, 16'h1234);
    checkOutput("mulRsvFlags", FlagsOut, 4'b0000);
`endif

    // Abort a long op with reset
    @(negedge Clock);
`ifdef SEQ_ALU_MUL_EN
    FunSel = 4'd13; B = 16'h0103;
`else
    FunSel = 4'd8;  B = 16'h000F;
`endif
    A = 16'h00FF; WF = 1'b1; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    checkOutput("abortBusy", Busy, 0);
    checkOutput("abortDone", Done, 0);
    checkOutput("abortOut", ALUOut, 0);
    checkOutput("abortFlags", FlagsOut, 0);
    modelFlags = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (Done) sawDone = 1'b1;
    end
    checkOutput("noDoneAfterAbort", sawDone, 0);
    @(negedge Clock);
    applyStimulus(4'd1, 16'h0001, 16'h0001, 1'b1);
    checkOutput("postAbortAdd", ALUOut, 16'h0002);

    // Random operations, mixing back-to-back issue with idle gaps
    for (int i = 0; i < 80; i++) begin
      fun = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge Clock); #1;
        checkOutput("donePulse", Done, 0);
      end
      applyStimulus(fun, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
